gs_dac_mixer: RTL and testbench



---
 rtl/gs_audio_pkg.sv | 31 +++
 rtl/gs_dac_mixer_ds_mod1.sv | 36 +++
 rtl/gs_dac_mixer.sv | 109 ++++++++++
 tb/tb_gs_dac_mixer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_audio_pkg.sv
// Shared constants and helpers for the General Sound audio path:
// frame timing, mix width, modulator offset and channel-to-side routing.
package gs_audio_pkg;

    localparam int          FRAME_LEN      = 32;
    localparam int          MIX_W          = 15;
    localparam int          NUM_CHAN       = 4;
    localparam int          VOL_W          = 6;
    localparam logic [4:0]  LAST_PHASE     = 5'(FRAME_LEN - 1);
    localparam logic [4:0]  FIRST_ACC      = 5'd1;
    localparam logic [4:0]  LAST_ACC       = 5'd24;
    localparam logic [4:0]  COMMIT_PHASE   = 5'd25;
    localparam logic [14:0] DS_OFFSET      = 15'd16384;

    typedef enum logic {
        SIDE_LEFT  = 1'b0,
        SIDE_RIGHT = 1'b1
    } side_e;

    // Channels 0,1 feed the left mix, channels 2,3 the right mix.
    function automatic side_e chan_side(input logic [1:0] chan);
        side_e side;
        case (chan)
            2'd0, 2'd1: side = SIDE_LEFT;
            2'd2, 2'd3: side = SIDE_RIGHT;
            default:    side = SIDE_LEFT;
        endcase
        return side;
    endfunction

endpackage

// File: rtl/gs_dac_mixer_ds_mod1.sv
// First-order delta-sigma modulator: offsets a signed mix to unsigned and
// emits the accumulator carry as a 1-bit stream (density = u / 32768).
import gs_audio_pkg::*;

module ds_mod1 (
    input  logic        clk32,
    input  logic        rst_n,
    input  logic [14:0] mix,
    output logic        bit_out
);

    logic [14:0] u_s;
    logic [15:0] acc_next_s;
    logic [15:0] acc_r;
    logic        bit_r;

    // Offset the signed mix and add it to the carry-stripped accumulator.
    always_comb begin
        u_s        = mix + DS_OFFSET;
        acc_next_s = {1'b0, acc_r[14:0]} + {1'b0, u_s};
    end

    // Accumulator and registered carry output.
    always_ff @(posedge clk32) begin
        if (!rst_n) begin
            acc_r <= 16'd0;
            bit_r <= 1'b0;
        end else begin
            acc_r <= acc_next_s;
            bit_r <= acc_next_s[15];
        end
    end

    assign bit_out = bit_r;

endmodule

// File: rtl/gs_dac_mixer.sv
// GS DAC mixer: per-frame snapshot of four samples/volumes, shared shift-add
// volume scaling into left/right partials, commit, and two 1-bit modulators.
import gs_audio_pkg::*;

module gs_dac_mixer (
    input  logic        clk32,
    input  logic        rst_n,
    input  logic        gs_ena,
    input  logic [7:0]  dac0,
    input  logic [7:0]  dac1,
    input  logic [7:0]  dac2,
    input  logic [7:0]  dac3,
    input  logic [5:0]  vol0,
    input  logic [5:0]  vol1,
    input  logic [5:0]  vol2,
    input  logic [5:0]  vol3,
    output logic        out_l,
    output logic        out_r,
    output logic [14:0] mix_l,
    output logic [14:0] mix_r,
    output logic        mix_valid
);

    logic [4:0]       phase_r;
    logic [3:0][7:0]  dac_sh_r;
    logic [3:0][5:0]  vol_sh_r;
    logic [14:0]      part_l_r;
    logic [14:0]      part_r_r;
    logic [14:0]      mix_l_r;
    logic [14:0]      mix_r_r;
    logic             mix_valid_r;

    logic [4:0]       idx_s;
    logic [4:0]       chan_full_s;
    logic [4:0]       bit_full_s;
    logic [1:0]       chan_s;
    logic [2:0]       bit_s;
    logic [7:0]       samp_s;
    logic [14:0]      term_s;
    logic             add_s;

    // Decode phase into channel/bit and form the shifted signed partial product.
    always_comb begin
        idx_s       = phase_r - 5'd1;
        chan_full_s = idx_s / 5'd6;
        bit_full_s  = idx_s % 5'd6;
        chan_s      = chan_full_s[1:0];
        bit_s       = bit_full_s[2:0];
        samp_s      = {~dac_sh_r[chan_s][7], dac_sh_r[chan_s][6:0]};
        term_s      = {{7{samp_s[7]}}, samp_s} << bit_s;
        if ((phase_r >= FIRST_ACC) && (phase_r <= LAST_ACC)) begin
            add_s = vol_sh_r[chan_s][bit_s];
        end else begin
            add_s = 1'b0;
        end
    end

    // Frame sequencer: snapshot, accumulate, commit.
    always_ff @(posedge clk32) begin
        if (!rst_n) begin
            phase_r     <= 5'd0;
            dac_sh_r    <= '0;
            vol_sh_r    <= '0;
            part_l_r    <= 15'd0;
            part_r_r    <= 15'd0;
            mix_l_r     <= 15'd0;
            mix_r_r     <= 15'd0;
            mix_valid_r <= 1'b0;
        end else begin
            phase_r     <= (phase_r == LAST_PHASE) ? 5'd0 : phase_r + 5'd1;
            mix_valid_r <= 1'b0;
            if (phase_r == 5'd0) begin
                dac_sh_r <= {dac3, dac2, dac1, dac0};
                vol_sh_r <= {vol3, vol2, vol1, vol0};
                part_l_r <= 15'd0;
                part_r_r <= 15'd0;
            end else if (add_s) begin
                if (chan_side(chan_s) == SIDE_LEFT) begin
                    part_l_r <= part_l_r + term_s;
                end else begin
                    part_r_r <= part_r_r + term_s;
                end
            end else if (phase_r == COMMIT_PHASE) begin
                mix_l_r     <= gs_ena ? part_l_r : 15'd0;
                mix_r_r     <= gs_ena ? part_r_r : 15'd0;
                mix_valid_r <= 1'b1;
            end
        end
    end

    ds_mod1 u_mod_l (
        .clk32   (clk32),
        .rst_n   (rst_n),
        .mix     (mix_l_r),
        .bit_out (out_l)
    );

    ds_mod1 u_mod_r (
        .clk32   (clk32),
        .rst_n   (rst_n),
        .mix     (mix_r_r),
        .bit_out (out_r)
    );

    assign mix_l     = mix_l_r;
    assign mix_r     = mix_r_r;
    assign mix_valid = mix_valid_r;

endmodule

// File: tb/tb_gs_dac_mixer.sv
// Directed bench for gs_dac_mixer: mix values, frame timing, reset and
// delta-sigma densities against hand-computed expectations.
module tb_gs_dac_mixer;

    logic        clk32;
    logic        rst_n;
    logic        gs_ena;
    logic [7:0]  dac0, dac1, dac2, dac3;
    logic [5:0]  vol0, vol1, vol2, vol3;
    logic        out_l, out_r;
    logic [14:0] mix_l, mix_r;
    logic        mix_valid;

    int n_cmp;
    int n_bad;

    localparam int WAIT_LIMIT = 200;

    gs_dac_mixer dut (
        .clk32     (clk32),
        .rst_n     (rst_n),
        .gs_ena    (gs_ena),
        .dac0      (dac0),
        .dac1      (dac1),
        .dac2      (dac2),
        .dac3      (dac3),
        .vol0      (vol0),
        .vol1      (vol1),
        .vol2      (vol2),
        .vol3      (vol3),
        .out_l     (out_l),
        .out_r     (out_r),
        .mix_l     (mix_l),
        .mix_r     (mix_r),
        .mix_valid (mix_valid)
    );

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    // Bounded wait for the next mix_valid; returns negedges elapsed.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk32);
            cyc++;
        end while (!mix_valid && cyc < WAIT_LIMIT);
        if (!mix_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_valid: got no mix_valid within %0d clocks", cyc);
        end
    endtask

    task automatic set_inputs(input logic [7:0] d0, d1, d2, d3,
                              input logic [5:0] v0, v1, v2, v3);
        dac0 = d0; dac1 = d1; dac2 = d2; dac3 = d3;
        vol0 = v0; vol1 = v1; vol2 = v2; vol3 = v3;
    endtask

    task automatic test_reset;
        int cyc;
        int pre;
        rst_n  = 1'b0;
        gs_ena = 1'b1;
        set_inputs(8'h80, 8'h80, 8'h80, 8'h80, 6'd63, 6'd63, 6'd63, 6'd63);
        repeat (4) @(negedge clk32);
        n_cmp++;
        if ({mix_l, mix_r, mix_valid, out_l, out_r} !== 33'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got mix_l=%0d mix_r=%0d valid=%b out=%b%b, want all 0",
                     $signed(mix_l), $signed(mix_r), mix_valid, out_l, out_r);
        end
        rst_n = 1'b1;
        pre = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk32);
            pre++;
            n_cmp++;
            if (out_l !== 1'(i % 2)) begin
                n_bad++;
                $display("FAIL reset_out_l_pattern[%0d]: got %b want %b", i, out_l, 1'(i % 2));
            end
        end
        wait_valid(cyc);
        n_cmp++;
        if (pre + cyc != 26) begin
            n_bad++;
            $display("FAIL first_valid_latency: got %0d want 26", pre + cyc);
        end
        n_cmp++;
        if (mix_l !== 15'd0 || mix_r !== 15'd0) begin
            n_bad++;
            $display("FAIL silence_mix: got %0d/%0d want 0/0", $signed(mix_l), $signed(mix_r));
        end
    endtask

    task automatic test_full_scale_left;
        int cyc;
        int ones;
        set_inputs(8'hFF, 8'h80, 8'h80, 8'h80, 6'd63, 6'd63, 6'd63, 6'd63);
        wait_valid(cyc);
        wait_valid(cyc);
        n_cmp++;
        if (mix_l !== 15'd8001 || mix_r !== 15'd0) begin
            n_bad++;
            $display("FAIL full_scale_mix: got %0d/%0d want 8001/0", $signed(mix_l), $signed(mix_r));
        end
        ones = 0;
        for (int i = 0; i < 32768; i++) begin
            @(negedge clk32);
            ones += int'(out_l);
        end
        n_cmp++;
        if (ones != 24385) begin
            n_bad++;
            $display("FAIL full_scale_density: got %0d ones want 24385", ones);
        end
    endtask

    task automatic test_negative;
        int cyc;
        int ones;
        set_inputs(8'h00, 8'h00, 8'h40, 8'h80, 6'd63, 6'd63, 6'd1, 6'd63);
        wait_valid(cyc);
        wait_valid(cyc);
        n_cmp++;
        if (mix_l !== 15'(-16128) || mix_r !== 15'(-64)) begin
            n_bad++;
            $display("FAIL negative_mix: got %0d/%0d want -16128/-64", $signed(mix_l), $signed(mix_r));
        end
        ones = 0;
        for (int i = 0; i < 1280; i++) begin
            @(negedge clk32);
            ones += int'(out_l);
        end
        n_cmp++;
        if (ones != 10) begin
            n_bad++;
            $display("FAIL min_density: got %0d ones in 1280 want 10", ones);
        end
    endtask

    task automatic test_zero_volume;
        int cyc;
        set_inputs(8'hFF, 8'h00, 8'hFF, 8'h00, 6'd0, 6'd0, 6'd0, 6'd0);
        wait_valid(cyc);
        for (int f = 0; f < 3; f++) begin
            dac0 = 8'($urandom); dac1 = 8'($urandom);
            dac2 = 8'($urandom); dac3 = 8'($urandom);
            wait_valid(cyc);
            n_cmp++;
            if (mix_l !== 15'd0 || mix_r !== 15'd0) begin
                n_bad++;
                $display("FAIL zero_volume[%0d]: got %0d/%0d want 0/0", f, $signed(mix_l), $signed(mix_r));
            end
        end
    endtask

    task automatic test_gs_ena;
        int cyc;
        set_inputs(8'hFF, 8'hFF, 8'h00, 8'h00, 6'd63, 6'd63, 6'd63, 6'd63);
        gs_ena = 1'b0;
        wait_valid(cyc);
        wait_valid(cyc);
        n_cmp++;
        if (mix_l !== 15'd0 || mix_r !== 15'd0) begin
            n_bad++;
            $display("FAIL gs_ena_off: got %0d/%0d want 0/0", $signed(mix_l), $signed(mix_r));
        end
        gs_ena = 1'b1;
        wait_valid(cyc);
        repeat (16) @(negedge clk32);
        gs_ena = 1'b0;
        repeat (5) @(negedge clk32);
        gs_ena = 1'b1;
        wait_valid(cyc);
        n_cmp++;
        if (mix_l !== 15'd16002 || mix_r !== 15'(-16128)) begin
            n_bad++;
            $display("FAIL gs_ena_midframe: got %0d/%0d want 16002/-16128", $signed(mix_l), $signed(mix_r));
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        set_inputs(8'h80, 8'h80, 8'h80, 8'h80, 6'd63, 6'd63, 6'd63, 6'd63);
        wait_valid(cyc);
        wait_valid(cyc);
        n_cmp++;
        if (cyc != 32) begin
            n_bad++;
            $display("FAIL valid_spacing: got %0d want 32", cyc);
        end
        repeat (16) @(negedge clk32);
        dac0 = 8'hFF;
        wait_valid(cyc);
        n_cmp++;
        if (cyc != 16 || mix_l !== 15'd0) begin
            n_bad++;
            $display("FAIL midframe_change_ignored: got cyc=%0d mix_l=%0d want 16/0", cyc, $signed(mix_l));
        end
        wait_valid(cyc);
        n_cmp++;
        if (cyc != 32 || mix_l !== 15'd8001) begin
            n_bad++;
            $display("FAIL next_frame_update: got cyc=%0d mix_l=%0d want 32/8001", cyc, $signed(mix_l));
        end
    endtask

    task automatic test_midframe_reset;
        int cyc;
        repeat (21) @(negedge clk32);
        rst_n = 1'b0;
        @(negedge clk32);
        n_cmp++;
        if ({mix_l, mix_r, mix_valid, out_l, out_r} !== 33'd0) begin
            n_bad++;
            $display("FAIL midframe_reset_outputs: got mix_l=%0d mix_r=%0d valid=%b out=%b%b, want all 0",
                     $signed(mix_l), $signed(mix_r), mix_valid, out_l, out_r);
        end
        rst_n = 1'b1;
        wait_valid(cyc);
        n_cmp++;
        if (cyc != 26 || mix_l !== 15'd8001) begin
            n_bad++;
            $display("FAIL post_reset_valid: got cyc=%0d mix_l=%0d want 26/8001", cyc, $signed(mix_l));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_full_scale_left();
        test_negative();
        test_zero_volume();
        test_gs_ena();
        test_back_to_back();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
